// File: rtl/jpeg_decoder_fifo_pkg.sv
`include "jpeg_decoder_fifo_defs.vh"
`default_nettype none
// ============================================================================
//  jpeg_decoder_fifo_pkg
//  Default configuration constants and the configuration-consistency helper
//  shared by the parametrised output FIFO and its RAM.
//  Revision: 1.0 - initial release
// ============================================================================
package jpeg_decoder_fifo_pkg;

   localparam int unsigned DEF_WIDTH  = `JPEG_DECODER_FIFO_DEF_WIDTH;
   localparam int unsigned DEF_DEPTH  = `JPEG_DECODER_FIFO_DEF_DEPTH;
   localparam int unsigned DEF_ADDR_W = `JPEG_DECODER_FIFO_DEF_ADDR_W;
   localparam int unsigned DEF_AFULL  = `JPEG_DECODER_FIFO_DEF_AFULL;

   function automatic bit fifo_cfg_ok(input int unsigned depth,
                                      input int unsigned addr_w,
                                      input int unsigned afull);
      return (depth == (32'd1 << addr_w)) && (depth >= 4) &&
             (afull >= 1) && (afull <= depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/jpeg_decoder_fifo_defs.vh
// ============================================================================
//  jpeg_decoder_fifo_defs.vh
//  Shared defaults and configuration check for the parametrised output FIFO.
//  Revision: 1.0 - initial release
// ============================================================================
`ifndef JPEG_DECODER_FIFO_DEFS_VH
`define JPEG_DECODER_FIFO_DEFS_VH
`default_nettype none

`define JPEG_DECODER_FIFO_DEF_WIDTH  32
`define JPEG_DECODER_FIFO_DEF_DEPTH  1024
`define JPEG_DECODER_FIFO_DEF_ADDR_W 10
`define JPEG_DECODER_FIFO_DEF_AFULL  768

// Elaboration-time guard: DEPTH must be 2**ADDR_W and at least 4, and the
// almost-full threshold must lie inside 1..DEPTH. Expands to a labelled
// generate block; relies on fifo_cfg_ok() from jpeg_decoder_fifo_pkg.
`define JPEG_DECODER_FIFO_CHECK_CFG(depth_p, addr_w_p, afull_p) \
   if (!fifo_cfg_ok((depth_p), (addr_w_p), (afull_p))) begin : g_bad_cfg \
      $error("jpeg_decoder_fifo_param: DEPTH must be 2**ADDR_W and >= 4, AFULL_LEVEL in 1..DEPTH"); \
   end

`default_nettype wire
`endif

// File: rtl/jpeg_decoder_fifo_ram_dp.sv
`default_nettype none
// ============================================================================
//  jpeg_decoder_fifo_ram_dp
//  Single-clock simple dual-port RAM: port 0 write-only, port 1 read-only with
//  a registered output. The storage array has no reset; only the read data
//  register is clearable so the FIFO output reads zero after reset/flush.
//
//  Ports:
//    clk      in   clock
//    clr      in   synchronous clear of the read data register
//    wr_en    in   write enable (port 0)
//    wr_addr  in   write address
//    wr_data  in   write data
//    rd_en    in   read enable (port 1), data appears one cycle later
//    rd_addr  in   read address
//    rd_data  out  registered read data
//  Revision: 1.0 - initial release
// ============================================================================
module jpeg_decoder_fifo_ram_dp
   import jpeg_decoder_fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   localparam int unsigned ENTRIES = 32'd1 << ADDR_W;

   logic [WIDTH-1:0] mem [0:ENTRIES-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/jpeg_decoder_fifo_param.sv
`include "jpeg_decoder_fifo_defs.vh"
`default_nettype none
// ============================================================================
//  jpeg_decoder_fifo_param
//  Parametrised first-word-fall-through FIFO between the IDCT/colour-convert
//  stages and the AXI output path. Registered-read RAM plus a one-entry skid
//  register that holds the head word while the consumer stalls.
//
//  Optional feature macro: JPEG_DECODER_FIFO_HWM_EN
//    defined   -> hwm_o reports the peak occupancy since reset/flush
//    undefined -> hwm_o tied to zero
//
//  Ports:
//    clk_i          in   clock
//    rst_i          in   synchronous reset, active-high (wins over flush_i)
//    flush_i        in   synchronous clear of contents
//    data_in_i      in   write data
//    push_i         in   write request
//    accept_o       out  push accepted this cycle
//    data_out_o     out  head-of-FIFO data
//    valid_o        out  data_out_o valid
//    pop_i          in   consume head (only when valid_o)
//    level_o        out  accepted, un-popped entries (0..DEPTH)
//    almost_full_o  out  level_o >= AFULL_LEVEL
//    hwm_o          out  occupancy high-watermark
//  Revision: 1.0 - initial release
// ============================================================================
module jpeg_decoder_fifo_param
   import jpeg_decoder_fifo_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned AFULL_LEVEL = DEF_AFULL
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [WIDTH-1:0]  data_in_i,
   input  logic              push_i,
   output logic              accept_o,
   output logic [WIDTH-1:0]  data_out_o,
   output logic              valid_o,
   input  logic              pop_i,
   output logic [ADDR_W:0]   level_o,
   output logic              almost_full_o,
   output logic [ADDR_W:0]   hwm_o
);

   `JPEG_DECODER_FIFO_CHECK_CFG(DEPTH, ADDR_W, AFULL_LEVEL)

   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_THR  = (ADDR_W+1)'(AFULL_LEVEL);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              ram_full;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_d;
   logic              rd_q;
   logic              skid_q;
   logic [WIDTH-1:0]  skid_data;
   logic [WIDTH-1:0]  ram_rdata;
   logic              clr;
   logic              push_acc;
   logic              pop_acc;
   logic              ram_ne;
   logic              rd_issue;

   assign clr      = rst_i | flush_i;

   // Based on the registered count only: a pop at full frees the slot for
   // the following cycle, never the current one.
   assign accept_o = (count_q != FULL_LEVEL) && !flush_i;
   assign push_acc = push_i & accept_o;
   assign valid_o  = skid_q | rd_q;
   assign pop_acc  = pop_i & valid_o;

   // wr_ptr == rd_ptr is ambiguous between empty and full RAM; ram_full
   // disambiguates using only the entries still resident in the array.
   assign ram_ne   = (wr_ptr != rd_ptr) || ram_full;

   // Prefetch whenever the output stage is empty or being drained.
   assign rd_issue = ram_ne && (!valid_o || pop_acc);

   assign data_out_o    = skid_q ? skid_data : ram_rdata;
   assign level_o       = count_q;
   assign almost_full_o = (count_q >= AFULL_THR);

   always_comb begin
      count_d = count_q;
      if (push_acc && !pop_acc) begin
         count_d = count_q + (ADDR_W+1)'(1);
      end else if (pop_acc && !push_acc) begin
         count_d = count_q - (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_full  <= 1'b0;
         count_q   <= '0;
         rd_q      <= 1'b0;
         skid_q    <= 1'b0;
         skid_data <= '0;
      end else begin
         count_q <= count_d;
         rd_q    <= rd_issue;
         if (push_acc) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (rd_issue) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         if (push_acc && !rd_issue) begin
            ram_full <= ((wr_ptr + ADDR_W'(1)) == rd_ptr);
         end else if (rd_issue && !push_acc) begin
            ram_full <= 1'b0;
         end
         // The registered RAM output would be lost once the next read lands,
         // so a stalled head word is parked in the skid register.
         if (valid_o && !pop_i) begin
            skid_q    <= 1'b1;
            skid_data <= data_out_o;
         end else begin
            skid_q    <= 1'b0;
            skid_data <= '0;
         end
      end
   end

   jpeg_decoder_fifo_ram_dp #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk_i),
      .clr     (clr),
      .wr_en   (push_acc & ~rst_i),
      .wr_addr (wr_ptr),
      .wr_data (data_in_i),
      .rd_en   (rd_issue & ~clr),
      .rd_addr (rd_ptr),
      .rd_data (ram_rdata)
   );

`ifdef JPEG_DECODER_FIFO_HWM_EN
   logic [ADDR_W:0] hwm_q;

   // Follows the registered count, so a new peak shows up one cycle after
   // the level changes. count_q never exceeds DEPTH, which bounds hwm_q.
   always_ff @(posedge clk_i) begin
      if (clr) begin
         hwm_q <= '0;
      end else if (count_q > hwm_q) begin
         hwm_q <= count_q;
      end
   end

   assign hwm_o = hwm_q;
`else
   assign hwm_o = '0;
`endif

endmodule

`default_nettype wire
